// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register-file responder: NUM_REGS x 32-bit software-visible registers
// with independent AW/W acceptance, byte-strobed commits and OKAY/SLVERR responses.
// Optional feature macro: REGFILE_RO_ID_EN -- register 0 becomes the read-only
// constant ID_VALUE (reads OKAY, writes SLVERR). Without it, register 0 is plain R/W.
module axi4_lite_regfile_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'h5243_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}           r_state_e;

  // Word index inside the local window; byte-offset bits [1:0] are ignored.
  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[2 +: IDX_W];
  endfunction

  // Any set bit above the index field means the access misses the register bank.
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] upper;
    upper = addr >> (2 + IDX_W);
    return |upper;
  endfunction

  function automatic logic write_rejected(input logic [ADDR_WIDTH-1:0] addr);
`ifdef REGFILE_RO_ID_EN
    return out_of_range(addr) || (reg_idx(addr) == '0);
`else
    return out_of_range(addr);
`endif
  endfunction

`ifndef REGFILE_RO_ID_EN
  // ID_VALUE only matters when the read-only ID register is built in.
  logic unused_id_value;
  assign unused_id_value = ^ID_VALUE;
`endif

  // Write-side state
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Read-side state
  r_state_e              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic aw_hs;
  logic w_hs;

  // Ready/valid outputs come straight from flops; no input-to-output paths.
  assign bvalid  = (w_state_q == W_RESP);
  assign awready = !aw_held_q && !bvalid;
  assign wready  = !w_held_q && !bvalid;
  assign bresp   = bresp_q;
  assign rvalid  = (r_state_q == R_DATA);
  assign arready = (r_state_q == R_IDLE);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Write channel: capture AW/W independently, commit once both are held, then respond.
  always_comb begin
    // NOTE: every _d takes its current value first, so no branch can leave it
    // unassigned and infer a latch.
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    case (w_state_q)
      W_IDLE: begin
        // A handshake this cycle counts as held, so same-cycle AW+W commit next cycle.
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        w_state_d = W_RESP;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        if (write_rejected(aw_addr_q)) begin
          bresp_d = RESP_SLVERR;
        end else begin
          bresp_d = RESP_OKAY;
          for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) begin
              regs_d[reg_idx(aw_addr_q)][8*i +: 8] = w_data_q[8*i +: 8];
            end
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-side registers, including the register bank itself.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the combinational blocks above use blocking ones.
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      // NOTE: the bank is small and software expects all-zero after reset, so it is
      // built from resettable flops rather than an unreset RAM macro.
      regs_q    <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
    end
  end

  // Read channel: capture data/response at the AR handshake and hold until rready.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_DATA;
          if (out_of_range(araddr)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
`ifdef REGFILE_RO_ID_EN
          else if (reg_idx(araddr) == '0) begin
            rdata_d = ID_VALUE;
            rresp_d = RESP_OKAY;
          end
`endif
          else begin
            // Reads the pre-commit bank, so a same-cycle commit is not visible yet.
            rdata_d = regs_q[reg_idx(araddr)];
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Scoreboard bench for axi4_lite_regfile_slave: stimulus tasks push expected B/R
// responses into queues; a negedge monitor pops and compares on every handshake.
module tb_axi4_lite_regfile_slave;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] ID_VAL = 32'h5243_0001;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16),
    .ID_VALUE  (ID_VAL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0] exp_b_q[$];
  r_exp_t     exp_r_q[$];

  // Monitor: a handshake completes at the posedge after a negedge with valid && ready.
  always @(negedge clk) begin : monitor
    r_exp_t e;
    if (!rst && bvalid && bready) begin
      check("b_expected_pending", exp_b_q.size() > 0, 1);
      if (exp_b_q.size() > 0) check("bresp", bresp, exp_b_q.pop_front());
    end
    if (!rst && rvalid && rready) begin
      check("r_expected_pending", exp_r_q.size() > 0, 1);
      if (exp_r_q.size() > 0) begin
        e = exp_r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", rresp, e.resp);
      end
    end
  end

  task automatic drive_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = awready;
    end
    @(posedge clk);
    #1 awvalid = 1'b0;
    check("aw_accepted", ok, 1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = wready;
    end
    @(posedge clk);
    #1 wvalid = 1'b0;
    check("w_accepted", ok, 1);
  endtask

  task automatic drive_ar(input logic [31:0] a);
    bit ok = 0;
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    check("ar_accepted", ok, 1);
  endtask

  // w_lead = 0: AW and W in the same cycle; otherwise W is accepted w_lead cycles before AW.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int stall, input logic [1:0] exp_resp);
    exp_b_q.push_back(exp_resp);
    bready = (stall == 0);
    if (w_lead == 0) begin
      fork
        drive_aw(a);
        drive_w(d, s);
      join
    end else begin
      drive_w(d, s);
      repeat (w_lead - 1) @(posedge clk);
      #1;
      drive_aw(a);
    end
    @(negedge clk);
    check("b_idle_in_commit", bvalid, 0);
    @(negedge clk);
    check("b_valid_latency", bvalid, 1);
    for (int i = 0; i < stall; i++) begin
      check("b_stall_valid", bvalid, 1);
      check("b_stall_resp", bresp, exp_resp);
      check("b_stall_awready", awready, 0);
      check("b_stall_wready", wready, 0);
      @(negedge clk);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1 bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("b_done", bvalid, 0);
    check("awready_after_b", awready, 1);
    check("wready_after_b", wready, 1);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp, input int stall);
    r_exp_t e;
    e.data = exp_d;
    e.resp = exp_resp;
    exp_r_q.push_back(e);
    rready = (stall == 0);
    drive_ar(a);
    @(negedge clk);
    check("r_valid_latency", rvalid, 1);
    for (int i = 0; i < stall; i++) begin
      check("r_stall_valid", rvalid, 1);
      check("r_stall_data", rdata, exp_d);
      check("r_stall_resp", rresp, exp_resp);
      check("r_stall_arready", arready, 0);
      @(negedge clk);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1 rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("r_done", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"},  wready,  1);
    check({tag, "_arready"}, arready, 1);
    check({tag, "_bvalid"},  bvalid,  0);
    check({tag, "_bresp"},   bresp,   0);
    check({tag, "_rvalid"},  rvalid,  0);
    check({tag, "_rresp"},   rresp,   0);
    check({tag, "_rdata"},   rdata,   0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] reg0_val;
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Same-cycle AW/W full-word write, then readback.
    write_txn(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY);
    read_txn(32'h08, 32'hDEAD_BEEF, OKAY, 0);

    // W three cycles ahead of AW, sparse strobes over an all-ones register.
    write_txn(32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, OKAY);
    write_txn(32'h0C, 32'h1122_3344, 4'b0101, 3, 0, OKAY);
    read_txn(32'h0C, 32'hFF22_FF44, OKAY, 0);

    // Back-pressure on B and R for five cycles.
    write_txn(32'h10, 32'hA5A5_0001, 4'hF, 0, 5, OKAY);
    read_txn(32'h10, 32'hA5A5_0001, OKAY, 5);

    // Zero strobes: OKAY with no change; low address bits are ignored on read.
    write_txn(32'h08, 32'h0000_0000, 4'h0, 0, 0, OKAY);
    read_txn(32'h0B, 32'hDEAD_BEEF, OKAY, 0);

    // Highest index, single top-lane strobe.
    write_txn(32'h3C, 32'h1234_5678, 4'b1000, 1, 0, OKAY);
    read_txn(32'h3C, 32'h1200_0000, OKAY, 0);

    // Register 0 behaviour depends on the build option.
`ifdef REGFILE_RO_ID_EN
    reg0_val = ID_VAL;
    read_txn(32'h00, ID_VAL, OKAY, 0);
    write_txn(32'h00, 32'h0000_00AA, 4'hF, 0, 0, SLVERR);
    read_txn(32'h00, ID_VAL, OKAY, 0);
`else
    reg0_val = 32'h0000_00AA;
    write_txn(32'h00, 32'h0000_00AA, 4'hF, 0, 0, OKAY);
    read_txn(32'h00, 32'h0000_00AA, OKAY, 0);
`endif

    // Out-of-range accesses: SLVERR, zero read data, bank untouched.
    write_txn(32'h40, 32'hDEAD_DEAD, 4'hF, 0, 0, SLVERR);
    read_txn(32'h40, 32'h0, SLVERR, 0);
    read_txn(32'h8000_0008, 32'h0, SLVERR, 0);
    read_txn(32'h00, reg0_val, OKAY, 0);
    read_txn(32'h3C, 32'h1200_0000, OKAY, 0);
    read_txn(32'h0C, 32'hFF22_FF44, OKAY, 0);
    read_txn(32'h08, 32'hDEAD_BEEF, OKAY, 0);

    // Reset in the cycle after an AW handshake, with W never sent.
    drive_aw(32'h14);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_bvalid", bvalid, 0);
      check("post_reset_awready", awready, 1);
    end
    @(posedge clk);
    #1;
    read_txn(32'h08, 32'h0, OKAY, 0);
`ifdef REGFILE_RO_ID_EN
    read_txn(32'h00, ID_VAL, OKAY, 0);
`else
    read_txn(32'h00, 32'h0, OKAY, 0);
`endif
    write_txn(32'h18, 32'h0BAD_F00D, 4'hF, 2, 0, OKAY);
    read_txn(32'h18, 32'h0BAD_F00D, OKAY, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
